// File: rtl/i2cmb_cmd_scheduler.sv
// Round-robin arbiter and command sequencer for a shared I2CMB core.
// Each grant runs set-bus/start/address/data/stop over Wishbone, polling CMDR after every command.
module i2cmb_cmd_scheduler #(
    parameter int NREQ       = 2,
    parameter int POLL_LIMIT = 4096,
    parameter int BUS_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*BUS_W-1:0] bus_id_i,
    input  logic [NREQ*7-1:0]     addr_i,
    input  logic [NREQ-1:0]       rw_i,
    input  logic [NREQ*8-1:0]     wdata_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  done_o,
    output logic [2:0]            status_o,
    output logic [7:0]            rdata_o,
    output logic                  busy_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [1:0]            adr_o,
    output logic [7:0]            dat_o,
    input  logic [7:0]            dat_i,
    input  logic                  ack_i
);
    // state   | meaning
    // INIT    | prepare the CSR enable write
    // IDLE    | arbitrate among pending requests
    // ACC     | Wishbone access in flight, waiting for ack_i
    // EVAL    | idle bus cycle; decide the next access from step/phase
    // DONE    | done_o pulse, status and read byte published
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ACC, ST_EVAL, ST_DONE} state_t;
    typedef enum logic [2:0] {SP_INIT, SP_SETBUS, SP_START, SP_ADDR, SP_DATA, SP_STOP} step_t;
    typedef enum logic [1:0] {PH_DPR, PH_CMDR, PH_POLL, PH_RDDPR} phase_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);
    localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;

    state_t state_q, state_d;
    step_t step_q, step_d, go_to;
    phase_t phase_q, phase_d;
    logic we_q, we_d;
    logic [1:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d, rd_q, rd_d;
    logic [CW-1:0] poll_q, poll_d;
    logic [PW-1:0] ptr_q, ptr_d, win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic busy_q, busy_d;
    logic [2:0] st_q, st_d, status_q, status_d;
    logic [7:0] rdata_q, rdata_d, rbyte_q, rbyte_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [6:0] addr_q, addr_d;
    logic rw_q, rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic go_step, start_poll, finish, found, err_path;
    logic [7:0] dpr_val;
    int idx;

    function automatic logic [7:0] cmd_code(step_t s, logic rw);
        case (s)
            SP_SETBUS: cmd_code = 8'h06;
            SP_START:  cmd_code = 8'h04;
            SP_ADDR:   cmd_code = 8'h01;
            SP_DATA:   cmd_code = rw ? 8'h03 : 8'h01;
            SP_STOP:   cmd_code = 8'h05;
            default:   cmd_code = 8'h00;
        endcase
    endfunction

    function automatic logic need_dpr(step_t s, logic rw);
        need_dpr = (s == SP_SETBUS) || (s == SP_ADDR) || (s == SP_DATA && !rw);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_INIT;
            step_q   <= SP_INIT;
            phase_q  <= PH_DPR;
            we_q     <= 1'b0;
            adr_q    <= 2'd0;
            dat_q    <= 8'd0;
            rd_q     <= 8'd0;
            poll_q   <= '0;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            st_q     <= 3'd0;
            status_q <= 3'd0;
            rdata_q  <= 8'd0;
            rbyte_q  <= 8'd0;
            bus_q    <= '0;
            addr_q   <= 7'd0;
            rw_q     <= 1'b0;
            wdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            phase_q  <= phase_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rd_q     <= rd_d;
            poll_q   <= poll_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            st_q     <= st_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            rbyte_q  <= rbyte_d;
            bus_q    <= bus_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        phase_d    = phase_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_d       = rd_q;
        poll_d     = poll_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        st_d       = st_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        rbyte_d    = rbyte_q;
        bus_d      = bus_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        go_step    = 1'b0;
        go_to      = SP_SETBUS;
        start_poll = 1'b0;
        finish     = 1'b0;
        found      = 1'b0;
        idx        = 0;
        dpr_val    = 8'd0;
        err_path   = (st_q != 3'd0);

        case (state_q)
            ST_INIT: begin
                state_d = ST_ACC;
                step_d  = SP_INIT;
                we_d    = 1'b1;
                adr_d   = A_CSR;
                dat_d   = 8'h80;
            end
            ST_IDLE: begin
                if (|req_i) begin
                    for (int i = 0; i < NREQ; i++) begin
                        idx = int'(ptr_q) + i;
                        if (idx >= NREQ) idx = idx - NREQ;
                        if (!found && req_i[idx]) begin
                            found   = 1'b1;
                            win_d   = PW'(idx);
                            gnt_d   = '0;
                            gnt_d[idx] = 1'b1;
                            bus_d   = bus_id_i[idx*BUS_W +: BUS_W];
                            addr_d  = addr_i[idx*7 +: 7];
                            rw_d    = rw_i[idx];
                            wdata_d = wdata_i[idx*8 +: 8];
                        end
                    end
                    busy_d  = 1'b1;
                    st_d    = 3'd0;
                    rbyte_d = 8'd0;
                    go_step = 1'b1;
                    go_to   = SP_SETBUS;
                end
            end
            ST_ACC: begin
                if (ack_i) begin
                    state_d = ST_EVAL;
                    if (!we_q) rd_d = dat_i;
                end
            end
            ST_EVAL: begin
                if (step_q == SP_INIT) begin
                    state_d = ST_IDLE;
                end else begin
                    case (phase_q)
                        PH_DPR: begin
                            state_d = ST_ACC;
                            we_d    = 1'b1;
                            adr_d   = A_CMDR;
                            dat_d   = cmd_code(step_q, rw_q);
                            phase_d = PH_CMDR;
                            poll_d  = '0;
                        end
                        PH_CMDR: start_poll = 1'b1;
                        PH_RDDPR: begin
                            rbyte_d = rd_q;
                            go_step = 1'b1;
                            go_to   = SP_STOP;
                        end
                        default: begin
                            // STOP only ends the transaction; an error already recorded wins
                            if (step_q == SP_STOP) begin
                                if (|rd_q[7:4]) begin
                                    finish = 1'b1;
                                    if (!err_path) begin
                                        if (rd_q[5]) st_d = 3'd2;
                                        else if (rd_q[4]) st_d = 3'd3;
                                        else if (rd_q[6]) st_d = 3'd1;
                                    end
                                end else if (poll_q == POLL_MAX) begin
                                    finish = 1'b1;
                                    if (!err_path) st_d = 3'd4;
                                end else begin
                                    start_poll = 1'b1;
                                end
                            end else if (rd_q[5]) begin
                                st_d   = 3'd2;
                                finish = 1'b1;
                            end else if (rd_q[4]) begin
                                st_d = 3'd3;
                                if (step_q == SP_SETBUS) begin
                                    finish = 1'b1;
                                end else begin
                                    go_step = 1'b1;
                                    go_to   = SP_STOP;
                                end
                            end else if (rd_q[6]) begin
                                st_d    = 3'd1;
                                go_step = 1'b1;
                                go_to   = SP_STOP;
                            end else if (rd_q[7]) begin
                                case (step_q)
                                    SP_SETBUS: begin go_step = 1'b1; go_to = SP_START; end
                                    SP_START:  begin go_step = 1'b1; go_to = SP_ADDR;  end
                                    SP_ADDR:   begin go_step = 1'b1; go_to = SP_DATA;  end
                                    SP_DATA: begin
                                        if (rw_q) begin
                                            state_d = ST_ACC;
                                            we_d    = 1'b0;
                                            adr_d   = A_DPR;
                                            dat_d   = 8'd0;
                                            phase_d = PH_RDDPR;
                                        end else begin
                                            go_step = 1'b1;
                                            go_to   = SP_STOP;
                                        end
                                    end
                                    default: finish = 1'b1;
                                endcase
                            end else if (poll_q == POLL_MAX) begin
                                st_d   = 3'd4;
                                finish = 1'b1;
                            end else begin
                                start_poll = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        if (start_poll) begin
            state_d = ST_ACC;
            we_d    = 1'b0;
            adr_d   = A_CMDR;
            dat_d   = 8'd0;
            phase_d = PH_POLL;
            poll_d  = poll_q + 1'b1;
        end

        if (go_step) begin
            case (go_to)
                SP_SETBUS: dpr_val = 8'(bus_d);
                SP_ADDR:   dpr_val = {addr_d, rw_d};
                default:   dpr_val = wdata_d;
            endcase
            step_d  = go_to;
            state_d = ST_ACC;
            we_d    = 1'b1;
            poll_d  = '0;
            if (need_dpr(go_to, rw_d)) begin
                adr_d   = A_DPR;
                dat_d   = dpr_val;
                phase_d = PH_DPR;
            end else begin
                adr_d   = A_CMDR;
                dat_d   = cmd_code(go_to, rw_d);
                phase_d = PH_CMDR;
            end
        end

        if (finish) begin
            state_d  = ST_DONE;
            gnt_d    = '0;
            status_d = st_d;
            rdata_d  = rbyte_d;
        end
    end

    assign cyc_o    = (state_q == ST_ACC);
    assign stb_o    = (state_q == ST_ACC);
    assign we_o     = we_q;
    assign adr_o    = adr_q;
    assign dat_o    = dat_q;
    assign gnt_o    = gnt_q;
    assign busy_o   = busy_q;
    assign done_o   = (state_q == ST_DONE);
    assign status_o = status_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_i2cmb_cmd_scheduler.sv
// Self-checking bench: Wishbone responder with a write scoreboard, table-driven transactions,
// plus round-robin, poll timeout and mid-transaction reset sequences.
module tb_i2cmb_cmd_scheduler;
    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  req = '0;
    logic [7:0]  bus_id = '0;
    logic [13:0] addr_v = '0;
    logic [1:0]  rw_v = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  gnt;
    logic        done;
    logic [2:0]  status;
    logic [7:0]  rdata;
    logic        busy, cyc, stb, we;
    logic [1:0]  adr;
    logic [7:0]  dat_o;
    logic [7:0]  dat_i = '0;
    logic        ack = 0;

    i2cmb_cmd_scheduler #(.NREQ(2), .POLL_LIMIT(8), .BUS_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .bus_id_i(bus_id), .addr_i(addr_v),
        .rw_i(rw_v), .wdata_i(wdata), .gnt_o(gnt), .done_o(done), .status_o(status),
        .rdata_o(rdata), .busy_o(busy), .cyc_o(cyc), .stb_o(stb), .we_o(we),
        .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r; int rw; int bus; int addr; int wd;
        int fstep; int fval; int rb;
        int last; int stp; int st;
    } vec_t;

    typedef struct { int st; int rd; int chk_rd; } exp_done_t;

    logic [9:0] exp_wr[$];
    exp_done_t  exp_done[$];
    int n_chk = 0, n_fail = 0;
    int fstep = 0, fval = 0, rbyte = 0;
    int cmd_cnt = 0, poll_cnt = 0, done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks every access one cycle after it appears
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && cyc && stb && !ack) begin
                if (we) begin
                    if (exp_wr.size() == 0) begin
                        chk("wb_write_unexpected", {adr, dat_o}, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wb_write", {adr, dat_o}, e);
                    end
                    if (adr == 2'd2) cmd_cnt++;
                end else if (adr == 2'd2) begin
                    poll_cnt++;
                    dat_i = (cmd_cnt == fstep) ? 8'(fval) : 8'h80;
                end else begin
                    dat_i = 8'(rbyte);
                end
                ack = 1;
            end else begin
                ack = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_writes(input int rw, input int bus, input int addr, input int wd,
                               input int last, input int stp);
        if (last >= 1) begin exp_wr.push_back({2'd1, 8'(bus)}); exp_wr.push_back({2'd2, 8'h06}); end
        if (last >= 2) exp_wr.push_back({2'd2, 8'h04});
        if (last >= 3) begin
            exp_wr.push_back({2'd1, 8'((addr << 1) | rw)});
            exp_wr.push_back({2'd2, 8'h01});
        end
        if (last >= 4) begin
            if (rw == 0) begin
                exp_wr.push_back({2'd1, 8'(wd)});
                exp_wr.push_back({2'd2, 8'h01});
            end else begin
                exp_wr.push_back({2'd2, 8'h03});
            end
        end
        if (stp != 0) exp_wr.push_back({2'd2, 8'h05});
    endtask

    task automatic drive(input int r, input int rw, input int bus, input int addr, input int wd);
        bus_id[r*4 +: 4] = 4'(bus);
        addr_v[r*7 +: 7] = 7'(addr);
        rw_v[r]          = rw[0];
        wdata[r*8 +: 8]  = 8'(wd);
        req[r]           = 1'b1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) begin ok = 1; break; end
        end
    endtask

    vec_t vecs[10];
    exp_done_t ed;
    bit ok;

    initial begin
        //          r rw bus addr  wd  fstep fval  rb   last stp st
        vecs[0] = '{0, 0, 1, 'h22, 'hA5, 0, 'h00, 'h00, 4, 1, 0};
        vecs[1] = '{1, 1, 2, 'h10, 'h00, 0, 'h00, 'h3C, 4, 1, 0};
        vecs[2] = '{0, 0, 3, 'h55, 'h11, 3, 'h40, 'h00, 3, 1, 1};
        vecs[3] = '{1, 0, 4, 'h33, 'h77, 2, 'h20, 'h00, 2, 0, 2};
        vecs[4] = '{0, 1, 15, 'h01, 'h00, 1, 'h10, 'h00, 1, 0, 3};
        vecs[5] = '{1, 0, 5, 'h7F, 'hFF, 4, 'h10, 'h00, 4, 1, 3};
        vecs[6] = '{0, 0, 6, 'h12, 'h34, 3, 'hF0, 'h00, 3, 0, 2};
        vecs[7] = '{1, 1, 7, 'h44, 'h00, 3, 'h50, 'h00, 3, 1, 3};
        vecs[8] = '{0, 1, 8, 'h2A, 'h00, 4, 'h40, 'hC3, 4, 1, 1};
        vecs[9] = '{1, 1, 0, 'h00, 'h00, 0, 'h00, 'h5A, 4, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {gnt, done, status, rdata, busy, cyc, stb, we, adr, dat_o}, 0);
        exp_wr.push_back({2'd0, 8'h80});
        rst = 0;

        foreach (vecs[k]) begin
            fstep = vecs[k].fstep; fval = vecs[k].fval; rbyte = vecs[k].rb;
            cmd_cnt = 0; poll_cnt = 0;
            push_writes(vecs[k].rw, vecs[k].bus, vecs[k].addr, vecs[k].wd, vecs[k].last, vecs[k].stp);
            exp_done.push_back('{vecs[k].st, vecs[k].rb, (vecs[k].st == 0 && vecs[k].rw == 1) ? 1 : 0});
            drive(vecs[k].r, vecs[k].rw, vecs[k].bus, vecs[k].addr, vecs[k].wd);
            wait_done(ok);
            chk($sformatf("vec%0d_done_seen", k), ok, 1);
            ed = exp_done.pop_front();
            req = '0;
            if (ok) begin
                chk($sformatf("vec%0d_status", k), status, ed.st);
                if (ed.chk_rd != 0) chk($sformatf("vec%0d_rdata", k), rdata, ed.rd);
                chk($sformatf("vec%0d_gnt_at_done", k), gnt, 0);
                chk($sformatf("vec%0d_busy_at_done", k), busy, 1);
                @(negedge clk);
                chk($sformatf("vec%0d_done_single", k), {done, busy}, 0);
            end
            chk($sformatf("vec%0d_writes_left", k), exp_wr.size(), 0);
            repeat (2) @(negedge clk);
        end

        // Round-robin with both requesters held continuously
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rr_reset_outputs", {gnt, done, busy, cyc}, 0);
        fstep = 0; rbyte = 'h3C;
        exp_wr.push_back({2'd0, 8'h80});
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_writes(0, 1, 'h22, 'hA5, 4, 1);
            else            push_writes(1, 2, 'h10, 0, 4, 1);
        end
        drive(0, 0, 1, 'h22, 'hA5);
        drive(1, 1, 2, 'h10, 0);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            chk($sformatf("rr%0d_grant", k), gnt, (k % 2 == 0) ? 1 : 2);
            chk($sformatf("rr%0d_busy", k), busy, 1);
            wait_done(ok);
            chk($sformatf("rr%0d_done_seen", k), ok, 1);
            chk($sformatf("rr%0d_status", k), status, 0);
            if (k % 2 == 1) chk($sformatf("rr%0d_rdata", k), rdata, 'h3C);
            if (k == 3) req = '0;
        end
        @(negedge clk);
        chk("rr_writes_left", exp_wr.size(), 0);
        repeat (2) @(negedge clk);

        // CMDR stuck at 0x00 on SETBUS: timeout after exactly 8 polls, no STOP
        fstep = 1; fval = 0; cmd_cnt = 0; poll_cnt = 0;
        push_writes(0, 11, 'h30, 'h99, 1, 0);
        drive(0, 0, 11, 'h30, 'h99);
        wait_done(ok);
        req = '0;
        chk("timeout_done_seen", ok, 1);
        chk("timeout_status", status, 4);
        chk("timeout_polls", poll_cnt, 8);
        @(negedge clk);
        chk("timeout_writes_left", exp_wr.size(), 0);
        repeat (2) @(negedge clk);

        // Reset during the data-byte poll
        fstep = 4; fval = 0; cmd_cnt = 0; poll_cnt = 0;
        push_writes(0, 9, 'h3A, 'h5E, 4, 0);
        drive(1, 0, 9, 'h3A, 'h5E);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_cnt == 4 && poll_cnt >= 6) begin ok = 1; break; end
        end
        chk("rst_reached_data_poll", ok, 1);
        #2 rst = 1;
        #1 chk("rst_async_outputs", {gnt, done, status, rdata, busy, cyc, stb, we, adr, dat_o}, 0);
        req = '0;
        chk("rst_writes_left", exp_wr.size(), 0);
        repeat (2) @(negedge clk);
        exp_wr.push_back({2'd0, 8'h80});
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_wr.size() == 0) break;
        end
        chk("rst_first_access_csr", exp_wr.size(), 0);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
